// File: rtl/core_timer.sv
// core_timer: machine timer (mtime/mtimecmp) and machine software interrupt
// (msip) unit behind a 64-bit request/grant register port.
//
// Ports:
//   clk_i, rst_ni      system clock, asynchronous active-low reset
//   rtc_i              asynchronous real-time-clock; each rising edge advances mtime
//   req_i/we_i         register access request / write (1) or read (0)
//   addr_i             byte address, bits [2:0] ignored
//   be_i, wdata_i      write byte enables and write data
//   gnt_o              grant, combinationally equal to req_i (always ready)
//   rvalid_o           response valid, one cycle after grant
//   rdata_o, err_o     read data and unmapped-address error, valid with rvalid_o
//   time_irq_o         registered (mtime >= mtimecmp)
//   sw_irq_o           msip register
//
// Handshake: a request is accepted on every clock edge where req_i is high
// (gnt_o = req_i). Exactly one response (rvalid_o high for one cycle) follows
// each accepted request in the next cycle, for reads and writes alike.
// Reads return the register contents from before the granting edge.
module core_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rtc_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        be_i,
  input  logic [63:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [63:0]       rdata_o,
  output logic              err_o,
  output logic              time_irq_o,
  output logic              sw_irq_o
);

  localparam logic [ADDR_W-1:0] MSIP_ADDR     = ADDR_W'(16'h0000);
  localparam logic [ADDR_W-1:0] MTIMECMP_ADDR = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] MTIME_ADDR    = ADDR_W'(16'hBFF8);

  // RTC synchronizer and edge detector
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;

  // Architectural state
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        time_irq_q, time_irq_d;

  // Response pipeline
  logic        rvalid_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [ADDR_W-4:0] word_addr;
  logic              sel_msip, sel_cmp, sel_time;
  logic [63:0]       mtime_inc;
  logic              unused_addr_lsb;

  function automatic logic [63:0] apply_be(input logic [63:0] base,
                                           input logic [63:0] wdata,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = base;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign tick            = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign word_addr       = addr_i[ADDR_W-1:3];
  assign unused_addr_lsb = ^addr_i[2:0];
  assign sel_msip        = (word_addr == MSIP_ADDR[ADDR_W-1:3]);
  assign sel_cmp         = (word_addr == MTIMECMP_ADDR[ADDR_W-1:3]);
  assign sel_time        = (word_addr == MTIME_ADDR[ADDR_W-1:3]);

  // A write to mtime on a tick edge masks onto the incremented value, so a
  // full write wins and the tick is lost; a partial write keeps the carry.
  assign mtime_inc = mtime_q + {63'd0, tick};

  always_comb begin
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = 64'd0;
    err_d      = 1'b0;
    time_irq_d = (mtime_q >= mtimecmp_q);
    if (req_i) begin
      err_d = ~(sel_msip | sel_cmp | sel_time);
      if (we_i) begin
        if (sel_msip && be_i[0]) msip_d     = wdata_i[0];
        if (sel_cmp)             mtimecmp_d = apply_be(mtimecmp_q, wdata_i, be_i);
        if (sel_time)            mtime_d    = apply_be(mtime_inc, wdata_i, be_i);
      end else begin
        if (sel_msip)      rdata_d = {63'd0, msip_q};
        else if (sel_cmp)  rdata_d = mtimecmp_q;
        else if (sel_time) rdata_d = mtime_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      time_irq_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rtc_i};
      edge_q     <= sync_q[SYNC_STAGES-1];
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      time_irq_q <= time_irq_d;
      rvalid_q   <= req_i;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign gnt_o      = req_i;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign err_o      = err_q;
  assign time_irq_o = time_irq_q;
  assign sw_irq_o   = msip_q;

endmodule

// File: tb/tb_core_timer.sv
module tb_core_timer;

  localparam logic [15:0] A_MSIP  = 16'h0000;
  localparam logic [15:0] A_CMP   = 16'h4000;
  localparam logic [15:0] A_TIME  = 16'hBFF8;
  localparam logic [15:0] A_BAD   = 16'h2000;
  localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rtc_i;
  logic        req_i;
  logic        we_i;
  logic [15:0] addr_i;
  logic [7:0]  be_i;
  logic [63:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;
  logic        time_irq_o;
  logic        sw_irq_o;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {err, rdata}
  logic [64:0] exp_q[$];

  core_timer #(.SYNC_STAGES(2), .ADDR_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rtc_i(rtc_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .time_irq_o(time_irq_o), .sw_irq_o(sw_irq_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every grant must be answered in the following cycle.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (exp_q.size() > 0 || rvalid_o) begin
        check("rvalid", {63'd0, rvalid_o}, {63'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
          logic [64:0] e;
          e = exp_q.pop_front();
          if (rvalid_o) begin
            check("rdata", rdata_o, e[63:0]);
            check("err", {63'd0, err_o}, {63'd0, e[64]});
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic bus(input logic we, input logic [15:0] addr, input logic [7:0] be,
                     input logic [63:0] wdata, input logic [63:0] exp_data,
                     input logic exp_err);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
    #1 check("gnt", {63'd0, gnt_o}, 64'd1);
    @(posedge clk_i);
    exp_q.push_back({exp_err, exp_data});
    #1 req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [63:0] data);
    bus(1'b1, addr, 8'hFF, data, 64'd0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [63:0] exp);
    bus(1'b0, addr, $urandom_range(0, 255), 64'd0, exp, 1'b0);
  endtask

  task automatic rtc_pulse;
    @(negedge clk_i) rtc_i = 1'b1;
    repeat (4) @(negedge clk_i);
    rtc_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; rtc_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
    addr_i = '0; be_i = '0; wdata_i = '0;
    #12;
    check("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_tirq", {63'd0, time_irq_o}, 64'd0);
    check("rst_sirq", {63'd0, sw_irq_o}, 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Reset values, back-to-back reads
    rd(A_MSIP, 64'd0);
    rd(A_CMP, ALL1);
    rd(A_TIME, 64'd0);
    repeat (2) @(posedge clk_i);
    #1 check("irq_after_reset", {63'd0, time_irq_o}, 64'd0);

    // Compare match
    wr(A_CMP, 64'd5);
    wr(A_TIME, 64'd0);
    repeat (4) begin
      rtc_pulse();
      check("irq_below_cmp", {63'd0, time_irq_o}, 64'd0);
    end
    @(negedge clk_i) rtc_i = 1'b1;
    repeat (3) @(posedge clk_i);   // mtime becomes 5 on the third edge
    #1 check("irq_same_edge", {63'd0, time_irq_o}, 64'd0);
    @(posedge clk_i);
    #1 check("irq_rise", {63'd0, time_irq_o}, 64'd1);
    repeat (3) @(negedge clk_i);
    rtc_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rd(A_TIME, 64'd5);
    wr(A_CMP, 64'd6);
    check("irq_hold", {63'd0, time_irq_o}, 64'd1);
    @(posedge clk_i);
    #1 check("irq_clear", {63'd0, time_irq_o}, 64'd0);

    // Wrap-around
    wr(A_CMP, ALL1);
    wr(A_TIME, 64'hFFFF_FFFF_FFFF_FFFE);
    rtc_pulse();
    check("irq_at_max", {63'd0, time_irq_o}, 64'd1);
    rtc_pulse();
    check("irq_after_wrap", {63'd0, time_irq_o}, 64'd0);
    rd(A_TIME, 64'd0);

    // Write colliding with tick: full, then partial
    wr(A_TIME, 64'hFF);
    @(negedge clk_i) rtc_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i);
    wr(A_TIME, 64'h100);           // granted on the tick edge
    @(negedge clk_i) rtc_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rd(A_TIME, 64'h100);
    wr(A_TIME, 64'h1FF);
    @(negedge clk_i) rtc_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i);
    bus(1'b1, A_TIME, 8'h01, 64'hAA, 64'd0, 1'b0);
    @(negedge clk_i) rtc_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rd(A_TIME, 64'h2AA);

    // msip and unmapped address
    wr(A_MSIP, ALL1);
    check("sw_irq_set", {63'd0, sw_irq_o}, 64'd1);
    rd(A_MSIP, 64'd1);
    wr(A_MSIP, 64'd0);
    check("sw_irq_clr", {63'd0, sw_irq_o}, 64'd0);
    bus(1'b0, A_BAD, 8'h00, 64'd0, 64'd0, 1'b1);
    rd(A_MSIP, 64'd0);
    rd(A_CMP, ALL1);
    rd(A_TIME, 64'h2AA);

    // Reset during a pending response
    rd(A_TIME, 64'h2AA);
    #2 rst_ni = 1'b0;
    #1 check("rst_mid_rvalid", {63'd0, rvalid_o}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    rd(A_TIME, 64'd0);
    repeat (3) rtc_pulse();
    rd(A_TIME, 64'd3);
    rd(A_CMP, ALL1);
    repeat (3) @(negedge clk_i);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_timer.md
# core_timer

Machine-timer and software-interrupt unit driving the CPU subsystem's `time_irq_i` input and providing the hart's software-interrupt line. It holds a 64-bit `mtime` counter advanced by a slow asynchronous real-time-clock input, a 64-bit `mtimecmp` compare register and a 1-bit `msip` register. All three are accessible over a 64-bit request/grant register port downstream of the system AXI-to-register bridge.

## Interface
Parameters:
- `SYNC_STAGES`, default 2, number of flops synchronizing `rtc_i`; legal range 2..4.
- `ADDR_W`, default 16, register-port address width.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `rtc_i`  in  1  asynchronous real-time-clock tick; each rising edge advances `mtime` by 1.
- `req_i`  in  1  register access request.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  ADDR_W  byte address; bits [2:0] ignored.
- `be_i`  in  8  write byte enables.
- `wdata_i`  in  64  write data.
- `gnt_o`  out  1  grant; equals `req_i` (combinational, always ready).
- `rvalid_o`  out  1  response valid, one cycle after grant.
- `rdata_o`  out  64  read data, valid with `rvalid_o`.
- `err_o`  out  1  unmapped-address error, valid with `rvalid_o`.
- `time_irq_o`  out  1  machine timer interrupt, registered.
- `sw_irq_o`  out  1  machine software interrupt; equals `msip`.

## Operation
- Address map (ADDR_W bits, bits [2:0] ignored):
  - 0x0000 `msip`: bit 0 is R/W; bits 63:1 read 0, writes ignored.
  - 0x4000 `mtimecmp`: 64-bit R/W.
  - 0xBFF8 `mtime`: 64-bit R/W.
  - Any other address: no state change, `rdata_o` = 0, `err_o` = 1.
- Writes are byte-masked. Byte i is updated only when `be_i[i]` = 1.
- A read with `we_i` = 0 ignores `be_i` and returns the full 64-bit value.
- Reads return the register value as it stood before the granting clock edge. Any update made on that same edge is not visible in the read data.
- RTC path:
  - `rtc_i` passes through SYNC_STAGES flops, then one edge-detect flop.
  - `tick` = synchronized & ~delayed.
  - `mtime` is incremented on each clock edge where `tick` = 1.
- `mtime` arithmetic is unsigned modulo 2^64. 0xFFFF_FFFF_FFFF_FFFF + 1 wraps to 0.
- Write to `mtime` in the same cycle as `tick`: next `mtime` is computed as follows.
  - Base value = `mtime` + 1.
  - Then each enabled byte of the base is replaced by `wdata_i`.
  - A full write therefore loads `wdata_i` exactly, and the tick is lost.
- `time_irq_o` next value = (`mtime` >= `mtimecmp`), unsigned 64-bit compare. Both operands are the current register values.
- `sw_irq_o` follows `msip` directly; it is a register output and never combinational from the bus.
- No state machine beyond the 1-cycle response pipeline. Back-to-back requests are accepted every cycle.

## Timing
- Reset values (asynchronous, all outputs and state):
  - `mtime` = 0, `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, `msip` = 0.
  - `time_irq_o` = 0, `sw_irq_o` = 0.
  - `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0.
  - Synchronizer and edge flops = 0.
- Register access: request granted at edge N produces `rvalid_o`, `rdata_o` and `err_o` during cycle N+1.
  - `rvalid_o` is deasserted one cycle after the last grant.
  - Writes also produce `rvalid_o`, with `rdata_o` = 0.
- RTC latency (SYNC_STAGES = 2): `rtc_i` first sampled high at edge k → `mtime` takes its incremented value at edge k+2.
  - `rtc_i` must stay high and low for at least SYNC_STAGES+1 clock cycles each. Faster toggling is unsupported.
- Interrupt latency:
  - A change of `mtime` or `mtimecmp` at edge N is reflected on `time_irq_o` at edge N+1.
  - A write of `msip` at edge N drives `sw_irq_o` from edge N onward.
- Reset asserted mid-access: any pending response is dropped and `rvalid_o` goes to 0 immediately. No response is produced after reset release.

## Test plan
- Reset, then read all three registers.
  - Response: 0x0, 0xFFFF_FFFF_FFFF_FFFF, 0x0.
  - Each `rvalid_o` arrives one cycle after its grant, with `err_o` = 0.
  - `time_irq_o` stays 0.
- Write `mtimecmp` = 5 and `mtime` = 0, then drive 5 `rtc_i` pulses.
  - `mtime` reads 5.
  - `time_irq_o` rises exactly one cycle after `mtime` becomes 5.
  - Writing `mtimecmp` = 6 clears `time_irq_o` one cycle later.
- Write `mtime` = 0xFFFF_FFFF_FFFF_FFFE, then apply 2 RTC pulses, with `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF.
  - `time_irq_o` = 1 after the first tick.
  - After the second tick `mtime` = 0 and `time_irq_o` = 0.
- Full write `mtime` = 0x100 in the same cycle as `tick` → `mtime` = 0x100.
  - Partial write with `be_i` = 0x01, `wdata_i` = 0xAA, while `mtime` = 0x1FF and `tick` = 1 → `mtime` = 0x2AA.
- Write `msip` with `wdata_i` = 0xFFFF_FFFF_FFFF_FFFF.
  - `sw_irq_o` = 1; read returns 0x1.
  - Writing 0 clears `sw_irq_o`.
  - Read of 0x2000 returns `rdata_o` = 0, `err_o` = 1, with no state change.
- Assert `rst_ni` low in the cycle after a read grant.
  - `rvalid_o` is 0 immediately; `mtime` = 0.
  - After release, RTC pulses count again from 0.
